// File: rtl/kmeans_point_loader.sv
// kmeans_point_loader: host-side loader for k_means_core.
// Packs a coordinate stream into RAM words, writes them through the core's
// load port, then raises go with the run window and threshold until the
// core signals interuptt.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   cfg_start/base/count/thr start request and run parameters
//   cfg_busy, cfg_error      status: busy outside IDLE, rejected-start pulse
//   coord_valid/data/ready   coordinate stream, one coordinate per beat
//   ram_address/data         packed point word and its RAM address
//   w_r_ram, chip_select_ram_n  active-low write strobe pair
//   go, first/last_ram_address, threshold_value  run request to the core
//   interuptt                core completion
//   done                     one-cycle run-complete pulse
module kmeans_point_loader #(
    parameter int addrWidth       = 9,
    parameter int dataWidth       = 91,
    parameter int cordinate_width = 13,
    parameter int dims            = 7,
    parameter int count_width     = 10,
    parameter int manhatten_width = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic [addrWidth-1:0]       cfg_base_addr,
    input  logic [count_width-1:0]     cfg_point_count,
    input  logic [manhatten_width-1:0] cfg_threshold,
    output logic                       cfg_busy,
    output logic                       cfg_error,
    input  logic                       coord_valid,
    input  logic [cordinate_width-1:0] coord_data,
    output logic                       coord_ready,
    output logic [addrWidth-1:0]       ram_address,
    output logic [dataWidth-1:0]       ram_data,
    output logic                       w_r_ram,
    output logic                       chip_select_ram_n,
    output logic                       go,
    output logic [addrWidth-1:0]       first_ram_address,
    output logic [addrWidth-1:0]       last_ram_address,
    output logic [manhatten_width-1:0] threshold_value,
    input  logic                       interuptt,
    output logic                       done
);

    localparam int CIW = $clog2(dims);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CIW-1:0]       LAST_COORD = CIW'(dims - 1);
    localparam logic [count_width:0] DEPTH      = (count_width + 1)'(1 << addrWidth);

    logic [2:0]                                  state_q, state_d;
    logic [CIW-1:0]                              coord_idx_q, coord_idx_d;
    logic [count_width-1:0]                      point_idx_q, point_idx_d;
    logic [addrWidth-1:0]                        base_q, base_d;
    logic [count_width-1:0]                      count_q, count_d;
    logic [dims-1:0][cordinate_width-1:0]        pack_q, pack_d;
    logic [addrWidth-1:0]                        ram_address_q, ram_address_d;
    logic [dataWidth-1:0]                        ram_data_q, ram_data_d;
    logic                                        w_r_ram_q, w_r_ram_d;
    logic                                        cs_n_q, cs_n_d;
    logic                                        go_q, go_d;
    logic [addrWidth-1:0]                        first_q, first_d;
    logic [addrWidth-1:0]                        last_q, last_d;
    logic [manhatten_width-1:0]                  thresh_q, thresh_d;
    logic                                        coord_ready_q, coord_ready_d;
    logic                                        done_q, done_d;
    logic                                        cfg_error_q, cfg_error_d;
    logic                                        cfg_busy_q, cfg_busy_d;

    // One extra bit so base+count can be compared against the RAM depth
    // without wrapping: base+count-1 > 511 is the same as base+count > 512.
    logic [count_width:0] span;
    logic                 start_bad;

    assign span = (count_width + 1)'(cfg_base_addr)
                + (count_width + 1)'(cfg_point_count);
    assign start_bad = (cfg_point_count == '0) || (span > DEPTH);

    always_comb begin
        state_d       = state_q;
        coord_idx_d   = coord_idx_q;
        point_idx_d   = point_idx_q;
        base_d        = base_q;
        count_d       = count_q;
        pack_d        = pack_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        w_r_ram_d     = 1'b1;
        cs_n_d        = 1'b1;
        go_d          = go_q;
        first_d       = first_q;
        last_d        = last_q;
        thresh_d      = thresh_q;
        coord_ready_d = coord_ready_q;
        done_d        = 1'b0;
        cfg_error_d   = 1'b0;
        cfg_busy_d    = cfg_busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (start_bad) begin
                        cfg_error_d = 1'b1;
                    end else begin
                        base_d        = cfg_base_addr;
                        count_d       = cfg_point_count;
                        point_idx_d   = '0;
                        coord_idx_d   = '0;
                        // The previous window stays visible until here.
                        first_d       = cfg_base_addr;
                        last_d        = cfg_base_addr
                                      + cfg_point_count[addrWidth-1:0]
                                      - 1'b1;
                        thresh_d      = cfg_threshold;
                        coord_ready_d = 1'b1;
                        cfg_busy_d    = 1'b1;
                        state_d       = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (coord_valid && coord_ready_q) begin
                    pack_d[coord_idx_q] = coord_data;
                    if (coord_idx_q == LAST_COORD) begin
                        coord_idx_d   = '0;
                        coord_ready_d = 1'b0;
                        cs_n_d        = 1'b0;
                        w_r_ram_d     = 1'b0;
                        ram_address_d = base_q
                                      + point_idx_q[addrWidth-1:0];
                        ram_data_d    = pack_d;
                        state_d       = ST_WRITE;
                    end else begin
                        coord_idx_d = coord_idx_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (point_idx_q == count_q - 1'b1) begin
                    go_d    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    point_idx_d   = point_idx_q + 1'b1;
                    coord_ready_d = 1'b1;
                    state_d       = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (interuptt) begin
                    go_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cfg_busy_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            coord_idx_q   <= '0;
            point_idx_q   <= '0;
            base_q        <= '0;
            count_q       <= '0;
            pack_q        <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            w_r_ram_q     <= 1'b1;
            cs_n_q        <= 1'b1;
            go_q          <= 1'b0;
            first_q       <= '0;
            last_q        <= '0;
            thresh_q      <= '0;
            coord_ready_q <= 1'b0;
            done_q        <= 1'b0;
            cfg_error_q   <= 1'b0;
            cfg_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            coord_idx_q   <= coord_idx_d;
            point_idx_q   <= point_idx_d;
            base_q        <= base_d;
            count_q       <= count_d;
            pack_q        <= pack_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            w_r_ram_q     <= w_r_ram_d;
            cs_n_q        <= cs_n_d;
            go_q          <= go_d;
            first_q       <= first_d;
            last_q        <= last_d;
            thresh_q      <= thresh_d;
            coord_ready_q <= coord_ready_d;
            done_q        <= done_d;
            cfg_error_q   <= cfg_error_d;
            cfg_busy_q    <= cfg_busy_d;
        end
    end

    assign cfg_busy          = cfg_busy_q;
    assign cfg_error         = cfg_error_q;
    assign coord_ready       = coord_ready_q;
    assign ram_address       = ram_address_q;
    assign ram_data          = ram_data_q;
    assign w_r_ram           = w_r_ram_q;
    assign chip_select_ram_n = cs_n_q;
    assign go                = go_q;
    assign first_ram_address = first_q;
    assign last_ram_address  = last_q;
    assign threshold_value   = thresh_q;
    assign done              = done_q;

endmodule
